// File: rtl/spm_hs_if.sv
// Valid/ready operand and product bundle for spm_hs.
// Carries the tc mode bit only when SPM_HS_MODE_EN is defined.
interface spm_hs_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
`ifdef SPM_HS_MODE_EN
  logic               tc;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid, x, y,
`ifdef SPM_HS_MODE_EN
    output tc,
`endif
    output out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, x, y,
`ifdef SPM_HS_MODE_EN
    input  tc,
`endif
    input  out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/spm_hs.sv
// Handshaked serial-parallel multiplier: y streamed LSB-first through a carry-save chain.
// SPM_HS_MODE_EN adds a per-operation tc select (signed/unsigned); otherwise always signed.
module spm_hs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  spm_hs_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic             load_c, run_c, cap_c, fin_c;
  logic [WIDTH-1:0] x_r, y_r, sum_r, carry_r;
  logic [WIDTH-1:0] pp_c, up_c, sum_n, carry_n;
  logic             fill_c, signed_c;
  logic [CW-1:0]    cnt;
  logic [PW-2:0]    prod_sr;
  logic [PW-1:0]    prod_shift_c, prod_r;
  logic             in_ready_r, out_valid_r;

`ifdef SPM_HS_MODE_EN
  logic tc_r;

  // Operation mode latched with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         tc_r <= 1'b0;
    else if (load_c) tc_r <= bus.tc;
  end

  assign signed_c = tc_r;
`else
  assign signed_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)         next_state = RUN;
      RUN:     if (cnt == CW'(PW))       next_state = DONE;
      DONE:    if (bus.out_ready)        next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    load_c = 1'b0;
    run_c  = 1'b0;
    cap_c  = 1'b0;
    fin_c  = 1'b0;
    case (state)
      IDLE: load_c = bus.in_valid;
      RUN: begin
        run_c = 1'b1;
        cap_c = (cnt != '0);
        fin_c = (cnt == CW'(PW));
      end
      default: ;
    endcase
  end

  assign pp_c         = x_r & {WIDTH{y_r[0]}};
  assign up_c         = {1'b0, sum_r[WIDTH-1:1]};
  assign fill_c       = signed_c & y_r[WIDTH-1];
  assign prod_shift_c = {sum_r[0], prod_sr};

  // Carry-save chain; the MSB cell negates its stream in signed mode (sticky carry)
  always_comb begin
    sum_n            = pp_c ^ up_c ^ carry_r;
    carry_n          = (pp_c & up_c) | (pp_c & carry_r) | (up_c & carry_r);
    carry_n[WIDTH-1] = signed_c ? (pp_c[WIDTH-1] | carry_r[WIDTH-1])
                                : (pp_c[WIDTH-1] & carry_r[WIDTH-1]);
  end

  // Operand, array and product registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= '0;
      y_r     <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      cnt     <= '0;
      prod_sr <= '0;
      prod_r  <= '0;
    end else if (load_c) begin
      x_r     <= bus.x;
      y_r     <= bus.y;
      sum_r   <= '0;
      carry_r <= '0;
      cnt     <= '0;
    end else if (run_c) begin
      y_r     <= {fill_c, y_r[WIDTH-1:1]};
      sum_r   <= sum_n;
      carry_r <= carry_n;
      if (!fin_c) cnt     <= cnt + CW'(1);
      if (cap_c)  prod_sr <= prod_shift_c[PW-1:1];
      if (fin_c)  prod_r  <= prod_shift_c;
    end
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state == IDLE);
      out_valid_r <= (next_state == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.prod      = prod_r;
endmodule

// File: doc/spm_hs.md
# spm_hs

Handshaked, parametrised serial-parallel multiplier. Accepts a WIDTH-bit multiplicand `x` and multiplier `y` in parallel, streams `y` LSB-first through a carry-save adder chain, and returns the full 2*WIDTH-bit product in parallel. It is the transaction-level successor to the bare bit-serial `spm` array: it adds internal serialisation, product deserialisation, a valid/ready interface and optional per-operation signed/unsigned selection.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range 2..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `x`  in  WIDTH  multiplicand, sampled on accept.
- `y`  in  WIDTH  multiplier, sampled on accept.
- `tc`  in  1  present only with `SPM_HS_MODE_EN`: 1 = two's-complement operands, 0 = unsigned; sampled on accept.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer takes product.
- `prod`  out  2*WIDTH  product of the last accepted operands.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, `in_ready`=1, `out_valid`=0, `prod`=0, all CSA cells, counter and shift registers 0.
- `in_ready` = (state==IDLE). Accept = `in_valid & in_ready`.
- IDLE -> RUN on accept: latch `x` into `x_r`, `y` into `y_r`, and the `tc` mode if present; clear every CSA sum/carry register synchronously; set `cnt`=0.
- RUN: the serial bit is `y_r[0]`. Each cycle `y_r` shifts right by one, filling with `y_r[WIDTH-1]` in signed mode and with 0 in unsigned mode. After WIDTH cycles the fed bit is the sign or zero extension of `y`.
- Array: cells 0..WIDTH-2 are carry-save adders with inputs `x_r[i] & ybit` and the sum of cell i+1. Cell WIDTH-1 is the two's-complement cell in signed mode and a plain adder with zero upper input in unsigned mode. The registered sum of cell 0 is the serial product bit `p`.
- Product capture: while RUN with `cnt` >= 1, `prod_sr` shifts right with `p` entering at bit 2*WIDTH-1. `cnt` increments each RUN cycle. At `cnt`==2*WIDTH, the final shift completes, `prod` is loaded from the shifted value, and the state moves to DONE.
- DONE: `out_valid`=1; `prod` is held stable. On `out_ready`, go to IDLE and clear `out_valid`.
- Arithmetic: `prod` = x*y modulo 2^(2*WIDTH). This equals the exact signed product in signed mode and the exact unsigned product in unsigned mode. There is no overflow flag.
- `in_valid` and the operand inputs are ignored outside IDLE. A change to `x` or `y` mid-operation has no effect.
- `rst` asserted in any state returns the block to reset values immediately. The in-flight operation is discarded and produces no output.

## Timing
- An accept at edge E0 causes `out_valid` to rise after edge E0+2*WIDTH+1, giving a latency of 2*WIDTH+1 cycles.
- `in_ready` is low from the cycle after E0 until the cycle after the `out_valid & out_ready` handshake.
- Minimum issue interval is 2*WIDTH+3 cycles when `out_ready` is tied high.
- `prod` changes only on the RUN->DONE transition or on reset. It remains valid after the handshake until the next completion.
- `out_ready` may be held low indefinitely; DONE persists with no state change.

## Configuration
- `SPM_HS_MODE_EN` defined: the `tc` port exists and signed or unsigned mode is selected per operation. The MSB cell and the `y` fill bit are muxed by the latched mode.
- Not defined: no `tc` port. Operation is always two's-complement and no mode mux is built.

## Test plan
- WIDTH=8, signed, x=50, y=-50 (8'hCE) -> `out_valid` exactly 17 cycles after accept, `prod`=16'hF63C.
- WIDTH=8, x=8'hFF, y=8'hFF: with tc=1 -> `prod`=16'h0001; with tc=0 (`SPM_HS_MODE_EN`) -> `prod`=16'hFE01.
- WIDTH=8, signed, x=8'h80, y=8'h80 -> `prod`=16'h4000. Also x=0, y=8'h7F -> `prod`=0.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`. `prod` must stay stable and `in_ready` must stay 0. Toggle `in_valid`, `x` and `y` during this time; there must be no effect. Release `out_ready` -> `in_ready`=1 one cycle later.
- Reset mid-operation: accept x=3, y=5 and assert `rst` at `cnt`==6. All outputs return to reset values at once. Then accept x=7, y=-2 -> `prod`=16'hFFF2 with no residue from the aborted operation.
- WIDTH=32, random signed and unsigned pairs issued back-to-back with `out_ready`=1. Each `prod` must match the reference model, with issue interval 67 cycles.
